// File: rtl/sl_ctrl_pkg.sv
// Shared types and constants for the anode front-end slow-control JTAG block.
// TAP state encoding is the one reported on the State port.
package sl_ctrl_pkg;

  localparam int IR_W   = 6;
  localparam int N_ADC  = 5;
  localparam int N_DAC  = 4;
  localparam int N_SB   = 42;
  localparam int N_GR   = 7;
  localparam int N_STRP = 6;
  localparam int DR_W   = N_SB;
  localparam int LEN_W  = 6;

  typedef enum logic [3:0] {
    ST_EX2DR   = 4'h0,
    ST_EX1DR   = 4'h1,
    ST_SHDR    = 4'h2,
    ST_PAUSEDR = 4'h3,
    ST_SELIR   = 4'h4,
    ST_UPDDR   = 4'h5,
    ST_CAPDR   = 4'h6,
    ST_SELDR   = 4'h7,
    ST_EX2IR   = 4'h8,
    ST_EX1IR   = 4'h9,
    ST_SHIR    = 4'hA,
    ST_PAUSEIR = 4'hB,
    ST_RTI     = 4'hC,
    ST_UPDIR   = 4'hD,
    ST_CAPIR   = 4'hE,
    ST_TLR     = 4'hF
  } tap_state_e;

  localparam logic [IR_W-1:0] OP_TP_DAC  = 6'h01;
  localparam logic [IR_W-1:0] OP_PD_TP   = 6'h02;
  localparam logic [IR_W-1:0] OP_TP_GR   = 6'h04;
  localparam logic [IR_W-1:0] OP_TP_STRP = 6'h06;
  localparam logic [IR_W-1:0] OP_DAC0    = 6'h08;
  localparam logic [IR_W-1:0] OP_RS_DAC  = 6'h0C;
  localparam logic [IR_W-1:0] OP_ADC0    = 6'h10;
  localparam logic [IR_W-1:0] OP_STANDBY = 6'h15;
  localparam logic [IR_W-1:0] OP_BYPASS  = 6'h3F;

  localparam logic [IR_W-1:0] IR_CAPTURE = 6'b000001;

  localparam logic              PD_TP_RST   = 1'b0;
  localparam logic [N_GR-1:0]   TP_GR_RST   = '0;
  localparam logic [N_STRP-1:0] TP_STRP_RST = '0;
  localparam logic [N_DAC-1:0]  RS_DAC_RST  = '1;
  localparam logic [N_SB-1:0]   SB_RST      = '0;

  // Active DR length for an opcode; anything without its own register is bypass.
  function automatic logic [LEN_W-1:0] dr_len(input logic [IR_W-1:0] op);
    case (op)
      OP_PD_TP:   dr_len = 6'd1;
      OP_TP_GR:   dr_len = 6'd7;
      OP_TP_STRP: dr_len = 6'd6;
      OP_RS_DAC:  dr_len = 6'd4;
      OP_STANDBY: dr_len = 6'd42;
      default:    dr_len = 6'd1;
    endcase
  endfunction

endpackage

// File: rtl/sl_ctrl_jtag_tap.sv
// IEEE 1149.1 TAP controller with 6-bit instruction register.
// state      | meaning
// TLR  (F)   | test-logic-reset, IR forced to BYPASS
// RTI  (C)   | run-test/idle
// SelDR(7)   | select DR scan
// CapDR(6)   | capture DR
// ShDR (2)   | shift DR
// Ex1DR(1)   | exit1 DR
// PauDR(3)   | pause DR
// Ex2DR(0)   | exit2 DR
// UpdDR(5)   | update DR
// SelIR(4)   | select IR scan
// CapIR(E)   | capture IR (loads 000001)
// ShIR (A)   | shift IR, TDI into MSB
// Ex1IR(9)   | exit1 IR
// PauIR(B)   | pause IR
// Ex2IR(8)   | exit2 IR
// UpdIR(D)   | update IR from shift register
module sl_ctrl_jtag_tap
  import sl_ctrl_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            tms_i,
  input  logic            tdi_i,
  output tap_state_e      state_o,
  output logic [IR_W-1:0] ir_o,
  output logic            ir_sr_lsb_o
);

  tap_state_e      state_q, state_d;
  logic [IR_W-1:0] ir_q, ir_d;
  logic [IR_W-1:0] ir_sr_q, ir_sr_d;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= ST_TLR;
      ir_q    <= OP_BYPASS;
      ir_sr_q <= IR_CAPTURE;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      ir_sr_q <= ir_sr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_TLR:     state_d = tms_i ? ST_TLR   : ST_RTI;
      ST_RTI:     state_d = tms_i ? ST_SELDR : ST_RTI;
      ST_SELDR:   state_d = tms_i ? ST_SELIR : ST_CAPDR;
      ST_CAPDR:   state_d = tms_i ? ST_EX1DR : ST_SHDR;
      ST_SHDR:    state_d = tms_i ? ST_EX1DR : ST_SHDR;
      ST_EX1DR:   state_d = tms_i ? ST_UPDDR : ST_PAUSEDR;
      ST_PAUSEDR: state_d = tms_i ? ST_EX2DR : ST_PAUSEDR;
      ST_EX2DR:   state_d = tms_i ? ST_UPDDR : ST_SHDR;
      ST_UPDDR:   state_d = tms_i ? ST_SELDR : ST_RTI;
      ST_SELIR:   state_d = tms_i ? ST_TLR   : ST_CAPIR;
      ST_CAPIR:   state_d = tms_i ? ST_EX1IR : ST_SHIR;
      ST_SHIR:    state_d = tms_i ? ST_EX1IR : ST_SHIR;
      ST_EX1IR:   state_d = tms_i ? ST_UPDIR : ST_PAUSEIR;
      ST_PAUSEIR: state_d = tms_i ? ST_EX2IR : ST_PAUSEIR;
      ST_EX2IR:   state_d = tms_i ? ST_UPDIR : ST_SHIR;
      ST_UPDIR:   state_d = tms_i ? ST_SELDR : ST_RTI;
      default:    state_d = ST_TLR;
    endcase
  end

  always_comb begin
    ir_d    = ir_q;
    ir_sr_d = ir_sr_q;
    case (state_q)
      ST_TLR:   ir_d    = OP_BYPASS;
      ST_CAPIR: ir_sr_d = IR_CAPTURE;
      ST_SHIR:  ir_sr_d = {tdi_i, ir_sr_q[IR_W-1:1]};
      ST_UPDIR: ir_d    = ir_sr_q;
      default:  ;
    endcase
  end

  assign state_o     = state_q;
  assign ir_o        = ir_q;
  assign ir_sr_lsb_o = ir_sr_q[0];

endmodule

// File: rtl/sl_ctrl.sv
// Slow-control top: JTAG TAP, control data registers, TDO mux and
// falling-edge gating of the serial DAC/ADC ports.
module sl_ctrl
  import sl_ctrl_pkg::*;
(
  input  logic              TCK,
  input  logic              TRST_N,
  input  logic              TMS,
  input  logic              TDI,
  output logic              TDO,
  output logic              Din_TP,
  output logic              Clk_TP,
  output logic              CS_TP_N,
  output logic              PD_TP_N,
  output logic [N_ADC-1:0]  Din_ADC,
  input  logic [N_ADC-1:0]  Dout_ADC,
  output logic [N_ADC-1:0]  Clk_ADC,
  output logic [N_ADC-1:0]  CS_ADC_N,
  output logic [N_DAC-1:0]  Din_DAC,
  output logic [N_DAC-1:0]  Clk_DAC,
  output logic [N_DAC-1:0]  CS_DAC_N,
  output logic [N_DAC-1:0]  RS_DAC_N,
  output logic [N_SB-1:0]   Stand_By_N,
  output logic [N_GR-1:0]   TP_Gr_En,
  output logic [N_STRP-1:0] TP_Strp_En,
  output logic [IR_W-1:0]   OpCode,
  output logic [3:0]        State,
  output logic [7:0]        Future
);

  tap_state_e      tap_state;
  logic [IR_W-1:0] ir;
  logic            ir_sr_lsb;

  sl_ctrl_jtag_tap u_tap (
    .clk_i       (TCK),
    .rst_n_i     (TRST_N),
    .tms_i       (TMS),
    .tdi_i       (TDI),
    .state_o     (tap_state),
    .ir_o        (ir),
    .ir_sr_lsb_o (ir_sr_lsb)
  );

  logic              pd_tp_n_q, pd_tp_n_d;
  logic [N_GR-1:0]   tp_gr_en_q, tp_gr_en_d;
  logic [N_STRP-1:0] tp_strp_en_q, tp_strp_en_d;
  logic [N_DAC-1:0]  rs_dac_n_q, rs_dac_n_d;
  logic [N_SB-1:0]   stand_by_n_q, stand_by_n_d;
  logic [DR_W-1:0]   dr_sr_q, dr_sr_d;
  logic [DR_W-1:0]   cap_val;
  logic [LEN_W-1:0]  dr_msb;

  assign dr_msb = dr_len(ir) - 6'd1;

  always_comb begin
    cap_val = '0;
    case (ir)
      OP_PD_TP:   cap_val[0]           = pd_tp_n_q;
      OP_TP_GR:   cap_val[N_GR-1:0]    = tp_gr_en_q;
      OP_TP_STRP: cap_val[N_STRP-1:0]  = tp_strp_en_q;
      OP_RS_DAC:  cap_val[N_DAC-1:0]   = rs_dac_n_q;
      OP_STANDBY: cap_val[N_SB-1:0]    = stand_by_n_q;
      default:    cap_val              = '0;
    endcase
  end

  // Registers share one shift chain; TDI enters at the top of the active length.
  always_comb begin
    pd_tp_n_d    = pd_tp_n_q;
    tp_gr_en_d   = tp_gr_en_q;
    tp_strp_en_d = tp_strp_en_q;
    rs_dac_n_d   = rs_dac_n_q;
    stand_by_n_d = stand_by_n_q;
    dr_sr_d      = dr_sr_q;
    case (tap_state)
      ST_TLR: begin
        pd_tp_n_d    = PD_TP_RST;
        tp_gr_en_d   = TP_GR_RST;
        tp_strp_en_d = TP_STRP_RST;
        rs_dac_n_d   = RS_DAC_RST;
        stand_by_n_d = SB_RST;
      end
      ST_CAPDR: dr_sr_d = cap_val;
      ST_SHDR: begin
        dr_sr_d         = dr_sr_q >> 1;
        dr_sr_d[dr_msb] = TDI;
      end
      ST_UPDDR: begin
        case (ir)
          OP_PD_TP:   pd_tp_n_d    = dr_sr_q[0];
          OP_TP_GR:   tp_gr_en_d   = dr_sr_q[N_GR-1:0];
          OP_TP_STRP: tp_strp_en_d = dr_sr_q[N_STRP-1:0];
          OP_RS_DAC:  rs_dac_n_d   = dr_sr_q[N_DAC-1:0];
          OP_STANDBY: stand_by_n_d = dr_sr_q[N_SB-1:0];
          default:    ;
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge TCK) begin
    if (!TRST_N) begin
      pd_tp_n_q    <= PD_TP_RST;
      tp_gr_en_q   <= TP_GR_RST;
      tp_strp_en_q <= TP_STRP_RST;
      rs_dac_n_q   <= RS_DAC_RST;
      stand_by_n_q <= SB_RST;
      dr_sr_q      <= '0;
    end else begin
      pd_tp_n_q    <= pd_tp_n_d;
      tp_gr_en_q   <= tp_gr_en_d;
      tp_strp_en_q <= tp_strp_en_d;
      rs_dac_n_q   <= rs_dac_n_d;
      stand_by_n_q <= stand_by_n_d;
      dr_sr_q      <= dr_sr_d;
    end
  end

  logic             shdr;
  logic             sel_tp_q, sel_tp_d;
  logic [N_DAC-1:0] sel_dac_q, sel_dac_d;
  logic [N_ADC-1:0] sel_adc_q, sel_adc_d;
  logic [N_ADC-1:0] adc_hit;
  logic             tdo_q, tdo_d;

  assign shdr = (tap_state == ST_SHDR);

  always_comb begin
    sel_dac_d = '0;
    adc_hit   = '0;
    sel_tp_d  = shdr && (ir == OP_TP_DAC);
    for (int k = 0; k < N_DAC; k++) begin
      sel_dac_d[k] = shdr && (ir == (OP_DAC0 + IR_W'(k)));
    end
    for (int k = 0; k < N_ADC; k++) begin
      adc_hit[k] = (ir == (OP_ADC0 + IR_W'(k)));
    end
    sel_adc_d = adc_hit & {N_ADC{shdr}};
  end

  always_comb begin
    tdo_d = tdo_q;
    if (tap_state == ST_TLR) begin
      tdo_d = 1'b0;
    end else if (tap_state == ST_SHIR) begin
      tdo_d = ir_sr_lsb;
    end else if (shdr) begin
      tdo_d = (|adc_hit) ? |(Dout_ADC & adc_hit) : dr_sr_q[0];
    end
  end

  // Selects change only while TCK is low, so TCK & sel cannot glitch.
  always_ff @(negedge TCK) begin
    sel_tp_q  <= sel_tp_d;
    sel_dac_q <= sel_dac_d;
    sel_adc_q <= sel_adc_d;
    tdo_q     <= tdo_d;
  end

  assign TDO        = tdo_q;
  assign Din_TP     = TDI;
  assign Clk_TP     = TCK & sel_tp_q;
  assign CS_TP_N    = ~sel_tp_q;
  assign PD_TP_N    = pd_tp_n_q;
  assign Din_ADC    = {N_ADC{TDI}};
  assign Clk_ADC    = {N_ADC{TCK}} & sel_adc_q;
  assign CS_ADC_N   = ~sel_adc_q;
  assign Din_DAC    = {N_DAC{TDI}};
  assign Clk_DAC    = {N_DAC{TCK}} & sel_dac_q;
  assign CS_DAC_N   = ~sel_dac_q;
  assign RS_DAC_N   = rs_dac_n_q;
  assign Stand_By_N = stand_by_n_q;
  assign TP_Gr_En   = tp_gr_en_q;
  assign TP_Strp_En = tp_strp_en_q;
  assign OpCode     = ir;
  assign State      = tap_state;
  assign Future     = 8'h00;

endmodule

// File: tb/tb_sl_ctrl.sv
// Directed bench for sl_ctrl with a queue-based TAP/register model checked every cycle.
module tb_sl_ctrl;

  logic        TCK = 1'b0;
  logic        TRST_N = 1'b0;
  logic        TMS = 1'b1;
  logic        TDI = 1'b0;
  logic        TDO;
  logic        Din_TP, Clk_TP, CS_TP_N, PD_TP_N;
  logic [4:0]  Din_ADC, Clk_ADC, CS_ADC_N;
  logic [4:0]  Dout_ADC = 5'b0;
  logic [3:0]  Din_DAC, Clk_DAC, CS_DAC_N, RS_DAC_N;
  logic [41:0] Stand_By_N;
  logic [6:0]  TP_Gr_En;
  logic [5:0]  TP_Strp_En;
  logic [5:0]  OpCode;
  logic [3:0]  State;
  logic [7:0]  Future;

  sl_ctrl dut (
    .TCK(TCK), .TRST_N(TRST_N), .TMS(TMS), .TDI(TDI), .TDO(TDO),
    .Din_TP(Din_TP), .Clk_TP(Clk_TP), .CS_TP_N(CS_TP_N), .PD_TP_N(PD_TP_N),
    .Din_ADC(Din_ADC), .Dout_ADC(Dout_ADC), .Clk_ADC(Clk_ADC), .CS_ADC_N(CS_ADC_N),
    .Din_DAC(Din_DAC), .Clk_DAC(Clk_DAC), .CS_DAC_N(CS_DAC_N), .RS_DAC_N(RS_DAC_N),
    .Stand_By_N(Stand_By_N), .TP_Gr_En(TP_Gr_En), .TP_Strp_En(TP_Strp_En),
    .OpCode(OpCode), .State(State), .Future(Future)
  );

  initial forever #5 TCK = ~TCK;

  int n_checks = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  int nxt0[16] = '{2, 3, 2, 3, 14, 12, 2, 6, 10, 11, 10, 11, 12, 12, 10, 12};
  int nxt1[16] = '{5, 5, 1, 0, 15, 7, 1, 4, 13, 13, 9, 8, 7, 7, 9, 15};

  int          m_st = 15;
  logic [5:0]  m_ir = 6'h3F;
  logic [41:0] m_sb;
  logic [6:0]  m_gr;
  logic [5:0]  m_strp;
  logic [3:0]  m_rs;
  logic        m_pd;
  bit          m_irq[$];
  bit          m_drq[$];
  logic [63:0] m_v;
  int          m_n;
  bit          model_ok = 1'b0;

  task automatic model_reset_regs();
    m_ir = 6'h3F; m_sb = '0; m_gr = '0; m_strp = '0; m_pd = 1'b0; m_rs = 4'hF;
  endtask

  always @(posedge TCK) begin
    if (!TRST_N) begin
      model_reset_regs();
      m_st = 15;
      m_irq.delete();
      m_drq.delete();
      model_ok = 1'b1;
    end else begin
      case (m_st)
        15: model_reset_regs();
        14: begin
          m_irq.delete();
          m_irq.push_back(1'b1);
          repeat (5) m_irq.push_back(1'b0);
        end
        10: begin void'(m_irq.pop_front()); m_irq.push_back(TDI); end
        13: for (int i = 0; i < 6; i++) m_ir[i] = m_irq[i];
        6: begin
          case (m_ir)
            6'h02: begin m_v = 64'(m_pd);   m_n = 1;  end
            6'h04: begin m_v = 64'(m_gr);   m_n = 7;  end
            6'h06: begin m_v = 64'(m_strp); m_n = 6;  end
            6'h0C: begin m_v = 64'(m_rs);   m_n = 4;  end
            6'h15: begin m_v = 64'(m_sb);   m_n = 42; end
            default: begin m_v = '0; m_n = 1; end
          endcase
          m_drq.delete();
          for (int i = 0; i < m_n; i++) m_drq.push_back(m_v[i]);
        end
        2: begin void'(m_drq.pop_front()); m_drq.push_back(TDI); end
        5: begin
          m_v = '0;
          for (int i = 0; i < m_drq.size(); i++) m_v[i] = m_drq[i];
          case (m_ir)
            6'h02: m_pd   = m_v[0];
            6'h04: m_gr   = m_v[6:0];
            6'h06: m_strp = m_v[5:0];
            6'h0C: m_rs   = m_v[3:0];
            6'h15: m_sb   = m_v[41:0];
            default: ;
          endcase
        end
        default: ;
      endcase
      m_st = TMS ? nxt1[m_st] : nxt0[m_st];
    end
  end

  // ---------------- compare process ----------------
  logic       m_tdo = 1'b0;
  logic       m_sel_tp;
  logic [3:0] m_sel_dac;
  logic [4:0] m_sel_adc;
  logic [9:0] m_cs;
  int         n_tp = 0;
  int         n_dac[4] = '{0, 0, 0, 0};
  int         n_adc[5] = '{0, 0, 0, 0, 0};

  initial begin
    forever begin
      @(negedge TCK); #1;
      if (model_ok) begin
        if (m_st == 15) m_tdo = 1'b0;
        else if (m_st == 10) m_tdo = m_irq[0];
        else if (m_st == 2) m_tdo = (m_ir >= 16 && m_ir <= 20) ? Dout_ADC[m_ir - 16] : m_drq[0];
        m_sel_tp = (m_st == 2) && (m_ir == 6'h01);
        for (int k = 0; k < 4; k++) m_sel_dac[k] = (m_st == 2) && (m_ir == 6'(8 + k));
        for (int k = 0; k < 5; k++) m_sel_adc[k] = (m_st == 2) && (m_ir == 6'(16 + k));
        m_cs = ~{m_sel_tp, m_sel_dac, m_sel_adc};
        chk("state", State, 64'(m_st));
        chk("opcode", OpCode, m_ir);
        chk("regs", {Stand_By_N, TP_Gr_En, TP_Strp_En, RS_DAC_N, PD_TP_N},
            {m_sb, m_gr, m_strp, m_rs, m_pd});
        chk("cs_n", {CS_TP_N, CS_DAC_N, CS_ADC_N}, m_cs);
        chk("tdo", TDO, m_tdo);
        chk("clk_low", {Clk_TP, Clk_DAC, Clk_ADC}, 64'd0);
        chk("future", Future, 64'd0);
      end
      @(posedge TCK); #1;
      if (model_ok) begin
        chk("clk_high", {Clk_TP, Clk_DAC, Clk_ADC}, {m_sel_tp, m_sel_dac, m_sel_adc});
        chk("din", {Din_TP, Din_DAC, Din_ADC}, {10{TDI}});
        if (Clk_TP) n_tp++;
        for (int k = 0; k < 4; k++) if (Clk_DAC[k]) n_dac[k]++;
        for (int k = 0; k < 5; k++) if (Clk_ADC[k]) n_adc[k]++;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick(input logic tms, input logic tdi);
    TMS = tms;
    TDI = tdi;
    @(posedge TCK);
    @(negedge TCK);
    #2;
  endtask

  // From RTI through a full IR scan back to RTI.
  task automatic scan_ir(input logic [5:0] op, output logic [5:0] tq);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      tq[i] = TDO;
      tick(i == 5, op[i]);
    end
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
  endtask

  task automatic scan_dr(input logic [63:0] bits, input int n, output logic [63:0] tq);
    tq = '0;
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    for (int i = 0; i < n; i++) begin
      tq[i] = TDO;
      tick(i == n - 1, bits[i]);
    end
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  logic [5:0]  itq;
  logic [63:0] dtq;
  int          tp0, dac0[4], adc0[5], others;
  logic [59:0] snap;

  initial begin
    TRST_N = 1'b0;
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    chk("rst_state", State, 64'hF);
    chk("rst_opcode", OpCode, 64'h3F);
    chk("rst_standby", Stand_By_N, 64'h0);
    chk("rst_rs_dac", RS_DAC_N, 64'hF);
    chk("rst_pd_tp", PD_TP_N, 64'h0);
    chk("rst_cs_tp", CS_TP_N, 64'h1);
    chk("rst_cs_adc", CS_ADC_N, 64'h1F);
    chk("rst_cs_dac", CS_DAC_N, 64'hF);
    chk("rst_tdo", TDO, 64'h0);
    TRST_N = 1'b1;
    tick(1'b0, 1'b0);

    // IR = TP DAC, capture pattern reads out 1,0,0,0,0,0
    scan_ir(6'h01, itq);
    chk("ir01_opcode", OpCode, 64'h01);
    chk("ir_capture_tdo", itq, 64'h01);

    tp0 = n_tp;
    scan_dr(64'b100, 3, dtq);
    chk("tp_clk_pulses", n_tp - tp0, 64'd3);
    chk("tp_cs_after", CS_TP_N, 64'h1);

    // standby register write and readback
    scan_ir(6'h15, itq);
    scan_dr(64'h2AAAAAAAAAA, 42, dtq);
    chk("standby_val", Stand_By_N, 64'h2AAAAAAAAAA);
    scan_dr(64'h2AAAAAAAAAA, 42, dtq);
    chk("standby_readback", dtq, 64'h2AAAAAAAAAA);

    // ADC 2 with Dout high
    scan_ir(6'h12, itq);
    Dout_ADC = 5'b00100;
    tp0 = n_tp;
    for (int k = 0; k < 5; k++) adc0[k] = n_adc[k];
    for (int k = 0; k < 4; k++) dac0[k] = n_dac[k];
    scan_dr(64'h0, 4, dtq);
    chk("adc2_tdo", dtq, 64'hF);
    chk("adc2_pulses", n_adc[2] - adc0[2], 64'd4);
    others = n_tp - tp0;
    for (int k = 0; k < 5; k++) if (k != 2) others += n_adc[k] - adc0[k];
    for (int k = 0; k < 4; k++) others += n_dac[k] - dac0[k];
    chk("adc2_other_pulses", others, 64'd0);
    Dout_ADC = 5'b0;

    // undefined opcode behaves as bypass
    scan_ir(6'h20, itq);
    snap = {Stand_By_N, TP_Gr_En, TP_Strp_En, RS_DAC_N, PD_TP_N};
    scan_dr(64'b1101, 4, dtq);
    chk("bypass_tdo", dtq, 64'b1010);
    chk("bypass_regs", {Stand_By_N, TP_Gr_En, TP_Strp_En, RS_DAC_N, PD_TP_N}, snap);
    chk("bypass_cs", {CS_TP_N, CS_DAC_N, CS_ADC_N}, 64'h3FF);

    // remaining registers
    scan_ir(6'h04, itq);
    scan_dr(64'h55, 7, dtq);
    chk("gr_val", TP_Gr_En, 64'h55);
    scan_ir(6'h06, itq);
    scan_dr(64'h2B, 6, dtq);
    chk("strp_val", TP_Strp_En, 64'h2B);
    scan_ir(6'h0C, itq);
    scan_dr(64'h6, 4, dtq);
    chk("rs_dac_val", RS_DAC_N, 64'h6);
    chk("rs_dac_old", dtq, 64'hF);
    scan_ir(6'h04, itq);
    scan_dr(64'h55, 7, dtq);
    chk("gr_readback", dtq, 64'h55);

    // DAC 1 serial port
    scan_ir(6'h09, itq);
    for (int k = 0; k < 4; k++) dac0[k] = n_dac[k];
    scan_dr(64'h15, 5, dtq);
    chk("dac1_pulses", n_dac[1] - dac0[1], 64'd5);
    chk("dac0_pulses", n_dac[0] - dac0[0], 64'd0);

    // Pause-DR drops CS, then five TMS=1 reach TLR
    scan_ir(6'h01, itq);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    chk("tp_cs_shdr", CS_TP_N, 64'h0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    chk("pause_state", State, 64'h3);
    chk("pause_cs", CS_TP_N, 64'h1);
    repeat (5) tick(1'b1, 1'b0);
    chk("five_tms_tlr", State, 64'hF);
    tick(1'b1, 1'b0);
    chk("tlr_opcode", OpCode, 64'h3F);
    chk("tlr_gr", TP_Gr_En, 64'h0);
    chk("tlr_rs_dac", RS_DAC_N, 64'hF);
    tick(1'b0, 1'b0);

    // TRST mid-scan aborts
    scan_ir(6'h02, itq);
    scan_dr(64'h1, 1, dtq);
    chk("pd_tp_set", PD_TP_N, 64'h1);
    scan_ir(6'h01, itq);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    chk("abort_cs_before", CS_TP_N, 64'h0);
    TRST_N = 1'b0;
    tick(1'b0, 1'b1);
    chk("abort_cs", CS_TP_N, 64'h1);
    chk("abort_state", State, 64'hF);
    chk("abort_pd", PD_TP_N, 64'h0);
    TRST_N = 1'b1;
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/sl_ctrl.md
Name: sl_ctrl

Overview:
- JTAG-controlled slow-control block for the anode front-end board.
- A standard 16-state IEEE 1149.1 TAP with a 6-bit instruction register selects one of several data registers or serial chip ports:
  - test-pulse amplitude DAC
  - 4 threshold DACs
  - 5 monitoring ADCs
  - standby / test-pulse enable control registers
- Sits between the board JTAG connector and the analog support chips. Serial chips are driven directly from the JTAG shift stream.

Parameters:
- IR_W, 6, instruction register width
- N_ADC, 5, number of ADC chips
- N_DAC, 4, number of threshold DAC chips
- N_SB, 42, standby register width

Ports:
- TCK in 1 JTAG clock, sole clock (rising edge; TDO and serial gating use falling edge)
- TRST_N in 1 reset, synchronous to TCK rising edge, active-low
- TMS in 1 test mode select
- TDI in 1 test data in
- TDO out 1 test data out
- Din_TP out 1 TP DAC serial data
- Clk_TP out 1 TP DAC serial clock
- CS_TP_N out 1 TP DAC chip select
- PD_TP_N out 1 TP circuit power-down, low = off
- Din_ADC out 5 ADC serial data
- Dout_ADC in 5 ADC serial data returned
- Clk_ADC out 5 ADC clocks
- CS_ADC_N out 5 ADC selects
- Din_DAC out 4 DAC serial data
- Clk_DAC out 4 DAC clocks
- CS_DAC_N out 4 DAC selects
- RS_DAC_N out 4 DAC resets
- Stand_By_N out 42 amplifier standby, low = standby
- TP_Gr_En out 7 test-pulse group enables
- TP_Strp_En out 6 test-pulse strip enables
- OpCode out 6 current IR contents
- State out 4 current TAP state
- Future out 8 spare, driven 8'h00

Behaviour:
- TAP next-state function is the IEEE 1149.1 table, evaluated on the TCK rising edge.
- State encoding, output on State:
  - TLR=F, RTI=C
  - SelDR=7, CapDR=6, ShDR=2, Ex1DR=1, PauseDR=3, Ex2DR=0, UpdDR=5
  - SelIR=4, CapIR=E, ShIR=A, Ex1IR=9, PauseIR=B, Ex2IR=8, UpdIR=D
- TRST_N=0 at a rising edge, or state TLR, produces:
  - state=TLR, IR=6'h3F (BYPASS)
  - Stand_By_N=0, TP_Gr_En=0, TP_Strp_En=0
  - PD_TP_N=0, RS_DAC_N=4'hF
- Five TMS=1 edges from any state reach TLR.
- IR handling:
  - Capture-IR loads the shift register with 6'b000001.
  - Shift-IR shifts LSB first; TDI enters at the MSB.
  - Update-IR copies the shift register to IR. OpCode = IR.
- Register instructions (read/write, one opcode each):
  - Capture-DR loads the current value into a DR shift register of the listed width.
  - Shift-DR shifts LSB first.
  - Update-DR writes the register.
  - A scan therefore returns the old value while writing the new one.
- Register opcodes:
  - 0x02 PD_TP_N (1)
  - 0x04 TP_Gr_En (7)
  - 0x06 TP_Strp_En (6)
  - 0x0C RS_DAC_N (4)
  - 0x15 Stand_By_N (42)
- Serial-port instructions (0x01 TP DAC; 0x08+k DAC k, k=0..3; 0x10+k ADC k, k=0..4):
  - sel_en register is updated on the TCK falling edge to (state==ShDR && IR matches).
  - CS_x_N = ~sel_en.
  - Clk_x = TCK & sel_en, so it is glitch-free and only clocks in Shift-DR.
  - Din_x = TDI.
  - For an ADC, the TDO source is Dout_ADC[k].
  - All unselected CS_N stay high and unselected clocks stay low.
  - Pause-DR deasserts CS at the next falling edge.
- BYPASS (0x3F and all undefined opcodes): 1-bit register, captures 0.
- TDO behaviour:
  - Updated on the TCK falling edge: the shift-register LSB in ShIR/ShDR, Dout_ADC[k] for ADC instructions.
  - Holds its last value in other states; it is not tri-stated.
  - Reset value 0.
- TRST_N low mid-scan aborts the scan with no register update. On the following falling edge CS lines go high.

Decomposition:
- Package sl_ctrl_pkg holds the TAP state enum (values above), opcode constants, and widths.
- Sub-module jtag_tap, containing the state machine and IR, is natural.
- sl_ctrl holds the data registers, TDO mux, and serial gating.

Test Plan:
- Hold TRST_N=0 for 2 TCK -> State=F, OpCode=3F, Stand_By_N=0, RS_DAC_N=F, all CS_N=1.
- TMS 0,1,1,0,0 then shift IR 6'h01 (TDI=1 on the first shift bit, TMS=1 on the last) and go to Update-IR -> OpCode=01, TDO during the IR shift reads out 1,0,0,0,0,0.
- With IR=0x01, scan 3 DR bits 0,0,1 -> CS_TP_N low only in Shift-DR, exactly 3 Clk_TP pulses, Din_TP follows TDI, CS_TP_N high after Exit1-DR.
- IR=0x15, scan 42 bits of alternating 1/0, then rescan -> Stand_By_N=42'h2AAAAAAAAAA after Update-DR, second scan's TDO returns the same pattern.
- IR=0x12, drive Dout_ADC[2]=1 -> only Clk_ADC[2]/CS_ADC_N[2] active, TDO=1 during shift.
- Undefined IR 0x20, 4-bit DR scan of 1,0,1,1 -> TDO delayed by one bit (0,1,0,1), no outputs change.
